// File: rtl/led_blink_if.sv
// Event-to-blink handshake bundle: the requester drives Trig, the driver reports
// LED state, queue depth and dropped requests.
interface led_blink_if #(
    parameter int PEND_W = 4
);
    logic              Trig;
    logic              Led;
    logic              Busy;
    logic [PEND_W-1:0] Pend_Cnt;
    logic              Overflow;

    modport master (
        output Trig,
        input  Led,
        input  Busy,
        input  Pend_Cnt,
        input  Overflow
    );

    modport slave (
        input  Trig,
        output Led,
        output Busy,
        output Pend_Cnt,
        output Overflow
    );
endinterface

// File: rtl/led_blink_driver.sv
// Turns 1-cycle event flags into visible LED blinks with guaranteed ON/OFF times.
// Requests arriving during a blink are queued in a saturating counter.
module led_blink_driver #(
    parameter int ON_CNT   = 10_000_000,
    parameter int OFF_CNT  = 10_000_000,
    parameter int CNT_W    = 24,
    parameter int MAX_PEND = 15,
    parameter int PEND_W   = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    led_blink_if.slave  blink
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_CNT - 1);
    localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_CNT - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  timer_reg, timer_next;
    logic [PEND_W-1:0] pend_reg, pend_next;
    logic              led_reg, led_next;
    logic              busy_reg, busy_next;
    logic              overflow_reg, overflow_next;
    logic              start;
    logic              accept;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg    <= S_IDLE;
            timer_reg    <= '0;
            pend_reg     <= '0;
            led_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            pend_reg     <= pend_next;
            led_reg      <= led_next;
            busy_reg     <= busy_next;
            overflow_reg <= overflow_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        start      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                timer_next = '0;
                if (pend_reg != '0) begin
                    state_next = S_ON;
                    start      = 1'b1;
                end
            end
            S_ON: begin
                if (timer_reg == ON_LAST) begin
                    state_next = S_OFF;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + CNT_W'(1);
                end
            end
            S_OFF: begin
                // Queued blinks restart straight from OFF so the period stays ON+OFF.
                if (timer_reg == OFF_LAST) begin
                    timer_next = '0;
                    if (pend_reg != '0) begin
                        state_next = S_ON;
                        start      = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    timer_next = timer_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                timer_next = '0;
            end
        endcase
    end

    // A full queue still takes a request on an edge that also starts a blink.
    always_comb begin
        accept        = blink.Trig && ((pend_reg < PEND_MAX) || start);
        overflow_next = blink.Trig && !accept;
        pend_next     = pend_reg;
        case ({accept, start})
            2'b10:   pend_next = pend_reg + PEND_ONE;
            2'b01:   pend_next = pend_reg - PEND_ONE;
            default: pend_next = pend_reg;
        endcase
        led_next  = (state_next == S_ON);
        busy_next = (state_next != S_IDLE);
    end

    assign blink.Led      = led_reg;
    assign blink.Busy     = busy_reg;
    assign blink.Pend_Cnt = pend_reg;
    assign blink.Overflow = overflow_reg;
endmodule
